// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit.
// Covers the operand-select encodings and the per-stage shadow record.
package fwd_pkg;

    // Record address field is sized for the widest supported register file.
    // Narrower addresses are zero-extended into it.
    localparam int MAX_AW = 8;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] dest;
        logic              wb_en;
        logic              mem_rd;
    } stage_rec_t;

endpackage

// File: rtl/fwd_src_match.sv
// Compares one ID source operand against the EX and MEM shadow records.
module fwd_src_match
    import fwd_pkg::*;
(
    input  logic [MAX_AW-1:0] src,
    input  logic              used,
    input  stage_rec_t        ex_rec,
    input  logic              mem_valid,
    input  logic [MAX_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              match_ex,
    output logic              match_mem,
    output logic              load_use
);

    always_comb begin
        match_ex  = used && ex_rec.valid && ex_rec.wb_en && (ex_rec.dest == src);
        match_mem = used && mem_valid && mem_wb_en && (mem_dest == src);
        load_use  = match_ex && ex_rec.mem_rd;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and stall control for a 5-stage pipeline.
// Tracks the EX/MEM/WB destinations and drives the registered EX operand selects.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     forward_en,
    input  logic                     freeze,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_src,
    input  logic [NSRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]        id_dest,
    input  logic                     id_wb_en,
    input  logic                     id_mem_rd,
    output logic                     stall,
    output logic [NSRC*2-1:0]        sel_src,
    output logic [CNT_W-1:0]         stall_count
);

    stage_rec_t        id_rec;
    stage_rec_t        ex_rec;
    stage_rec_t        mem_rec;
    stage_rec_t        wb_rec;
    logic [NSRC-1:0]   match_ex;
    logic [NSRC-1:0]   match_mem;
    logic [NSRC-1:0]   load_use;
    logic [NSRC*2-1:0] sel_next;

    // Invalid instructions enter EX as all-zero records, identical to bubbles.
    always_comb begin
        id_rec = '0;
        if (id_valid) begin
            id_rec.valid  = 1'b1;
            id_rec.dest   = MAX_AW'(id_dest);
            id_rec.wb_en  = id_wb_en;
            id_rec.mem_rd = id_mem_rd;
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        fwd_src_match u_match (
            .src       (MAX_AW'(id_src[k*REG_AW +: REG_AW])),
            .used      (id_src_used[k]),
            .ex_rec    (ex_rec),
            .mem_valid (mem_rec.valid),
            .mem_dest  (mem_rec.dest),
            .mem_wb_en (mem_rec.wb_en),
            .match_ex  (match_ex[k]),
            .match_mem (match_mem[k]),
            .load_use  (load_use[k])
        );
    end

    always_comb begin
        if (forward_en) begin
            stall = id_valid && (|load_use);
        end else begin
            stall = id_valid && (|(match_ex | match_mem));
        end
    end

    // The youngest producer (EX) wins when both stages write the same register.
    always_comb begin
        sel_next = '0;
        if (forward_en) begin
            for (int k = 0; k < NSRC; k++) begin
                if (match_ex[k]) begin
                    sel_next[k*2 +: 2] = SEL_EXMEM;
                end else if (match_mem[k]) begin
                    sel_next[k*2 +: 2] = SEL_MEMWB;
                end else begin
                    sel_next[k*2 +: 2] = SEL_RF;
                end
            end
        end
    end

    // ---- ID -> EX -> MEM -> WB record pipeline ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rec      <= '0;
            mem_rec     <= '0;
            wb_rec      <= '0;
            sel_src     <= '0;
            stall_count <= '0;
        end else if (!freeze) begin
            mem_rec <= ex_rec;
            wb_rec  <= mem_rec;
            if (flush || stall) begin
                ex_rec  <= '0;
                sel_src <= '0;
            end else begin
                ex_rec  <= id_rec;
                sel_src <= sel_next;
            end
            if (!flush && stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    // Empty WB slots are always fully zeroed, and no select ever carries 11.
    assert property (@(posedge clk) wb_rec.valid || (wb_rec == '0));
    for (genvar k = 0; k < NSRC; k++) begin : g_sel_chk
        assert property (@(posedge clk) sel_src[k*2 +: 2] != 2'b11);
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with an instruction-level reference model.
module tb_fwd_hazard_unit;

    localparam int REG_AW = 4;
    localparam int NSRC   = 2;
    localparam int CNT_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   forward_en;
    logic                   freeze;
    logic                   flush;
    logic                   id_valid;
    logic [NSRC*REG_AW-1:0] id_src;
    logic [NSRC-1:0]        id_src_used;
    logic [REG_AW-1:0]      id_dest;
    logic                   id_wb_en;
    logic                   id_mem_rd;
    logic                   stall;
    logic [NSRC*2-1:0]      sel_src;
    logic [CNT_W-1:0]       stall_count;

    fwd_hazard_unit #(.REG_AW(REG_AW), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .forward_en  (forward_en),
        .freeze      (freeze),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_rd   (id_mem_rd),
        .stall       (stall),
        .sel_src     (sel_src),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: instructions in flight, [0] = EX, [1] = MEM.
    typedef struct {
        bit v;
        int dest;
        bit wb;
        bit ld;
    } instr_t;

    instr_t pipe[2];
    int     m_sel[NSRC];
    int     m_cnt;
    bit     m_ok = 1'b0;

    function automatic int src_of(int k);
        return int'(id_src[k*REG_AW +: REG_AW]);
    endfunction

    function automatic bit produces(instr_t p, int k);
        return id_src_used[k] && p.v && p.wb && (p.dest == src_of(k));
    endfunction

    function automatic bit m_stall();
        bit lu  = 1'b0;
        bit any = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (produces(pipe[0], k)) begin
                any = 1'b1;
                if (pipe[0].ld) lu = 1'b1;
            end
            if (produces(pipe[1], k)) any = 1'b1;
        end
        return id_valid && (forward_en ? lu : any);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pipe[0] = '{0, 0, 0, 0};
            pipe[1] = '{0, 0, 0, 0};
            for (int k = 0; k < NSRC; k++) m_sel[k] = 0;
            m_cnt = 0;
            m_ok  = 1'b1;
        end else if (!freeze) begin
            bit     s;
            instr_t nxt;
            s   = m_stall();
            nxt = '{0, 0, 0, 0};
            if (!flush && !s) begin
                nxt = '{id_valid, int'(id_dest), id_wb_en, id_mem_rd};
                for (int k = 0; k < NSRC; k++) begin
                    if (!forward_en)                m_sel[k] = 0;
                    else if (produces(pipe[0], k))  m_sel[k] = 1;
                    else if (produces(pipe[1], k))  m_sel[k] = 2;
                    else                            m_sel[k] = 0;
                end
            end else begin
                for (int k = 0; k < NSRC; k++) m_sel[k] = 0;
            end
            if (!flush && s && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("cyc_stall", int'(stall), int'(m_stall()));
            for (int k = 0; k < NSRC; k++) begin
                check($sformatf("cyc_sel%0d", k), int'(sel_src[k*2 +: 2]), m_sel[k]);
            end
            check("cyc_count", int'(stall_count), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input int s0, input int s1, input bit [1:0] used,
                         input int d, input bit wb, input bit ld);
        id_valid    = v;
        id_src      = {REG_AW'(s1), REG_AW'(s0)};
        id_src_used = used;
        id_dest     = REG_AW'(d);
        id_wb_en    = wb;
        id_mem_rd   = ld;
        #1;
    endtask

    task automatic nop();
        issue(0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        nop();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        forward_en = 1'b1;
        freeze     = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        nop();
        tick();
        do_reset();
        check("reset_stall", int'(stall), 0);
        check("reset_sel", int'(sel_src), 0);
        check("reset_count", int'(stall_count), 0);

        // ADD r1; SUB r2 = r1 + r3 with forwarding
        issue(1, 2, 3, 2'b11, 1, 1, 0);
        check("add_sub_stall0", int'(stall), 0);
        tick();
        issue(1, 1, 3, 2'b11, 2, 1, 0);
        check("add_sub_stall1", int'(stall), 0);
        tick();
        check("add_sub_sel0", int'(sel_src[1:0]), 1);
        check("add_sub_sel1", int'(sel_src[3:2]), 0);
        nop();
        tick();
        check("add_sub_count", int'(stall_count), 0);

        // duplicate sources, unused-source masking, EX over MEM priority
        issue(1, 0, 0, 2'b00, 4, 1, 0);
        tick();
        issue(1, 4, 4, 2'b11, 6, 1, 0);
        tick();
        check("dup_src_sel", int'(sel_src), 5);
        issue(1, 6, 4, 2'b01, 7, 1, 0);
        tick();
        check("unused_src_sel", int'(sel_src), 1);
        issue(1, 0, 0, 2'b00, 5, 1, 0);
        tick();
        issue(1, 0, 0, 2'b00, 5, 1, 0);
        tick();
        issue(1, 5, 0, 2'b01, 8, 1, 0);
        tick();
        check("ex_priority_sel", int'(sel_src[1:0]), 1);

        // LDR r1; NOP; ADD r2 = r1
        do_reset();
        issue(1, 0, 0, 2'b00, 1, 1, 1);
        tick();
        nop();
        tick();
        issue(1, 1, 0, 2'b01, 2, 1, 0);
        check("ldr_nop_stall", int'(stall), 0);
        tick();
        check("ldr_nop_sel", int'(sel_src[1:0]), 2);

        // LDR r1; ADD r2 = r1 -> one load-use stall
        do_reset();
        issue(1, 0, 0, 2'b00, 1, 1, 1);
        tick();
        issue(1, 1, 0, 2'b01, 2, 1, 0);
        check("lu_stall", int'(stall), 1);
        tick();
        check("lu_bubble_sel", int'(sel_src), 0);
        check("lu_count_a", int'(stall_count), 1);
        check("lu_stall_released", int'(stall), 0);
        tick();
        check("lu_sel_after", int'(sel_src[1:0]), 2);
        check("lu_count_b", int'(stall_count), 1);
        check("model_lu_count", m_cnt, 1);

        // ADD; SUB dependency in stall-only mode
        do_reset();
        forward_en = 1'b0;
        issue(1, 2, 3, 2'b11, 1, 1, 0);
        tick();
        issue(1, 1, 3, 2'b11, 2, 1, 0);
        check("nofwd_stall_a", int'(stall), 1);
        tick();
        check("nofwd_count_a", int'(stall_count), 1);
        check("nofwd_stall_b", int'(stall), 1);
        tick();
        check("nofwd_count_b", int'(stall_count), 2);
        check("nofwd_stall_c", int'(stall), 0);
        tick();
        check("nofwd_sel", int'(sel_src), 0);
        check("model_nofwd_count", m_cnt, 2);
        forward_en = 1'b1;

        // load-use stall coinciding with flush
        do_reset();
        issue(1, 0, 0, 2'b00, 1, 1, 1);
        tick();
        flush = 1'b1;
        issue(1, 1, 0, 2'b01, 2, 1, 0);
        check("flush_stall_comb", int'(stall), 1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_count", int'(stall_count), 0);
        check("flush_sel", int'(sel_src), 0);
        check("flush_mem_shift", int'(stall), 0);

        // load-use stall coinciding with freeze
        do_reset();
        issue(1, 0, 0, 2'b00, 1, 1, 1);
        tick();
        freeze = 1'b1;
        issue(1, 1, 0, 2'b01, 2, 1, 0);
        check("freeze_stall_comb", int'(stall), 1);
        tick();
        tick();
        check("freeze_count", int'(stall_count), 0);
        check("freeze_ex_held", int'(stall), 1);
        freeze = 1'b0;
        #1;
        tick();
        check("unfreeze_count", int'(stall_count), 1);

        // freeze holds a non-zero select
        do_reset();
        issue(1, 0, 0, 2'b00, 3, 1, 0);
        tick();
        issue(1, 3, 0, 2'b01, 4, 1, 0);
        tick();
        freeze = 1'b1;
        nop();
        tick();
        tick();
        check("freeze_sel_held", int'(sel_src[1:0]), 1);
        freeze = 1'b0;
        #1;

        // reset in the middle of a stall
        do_reset();
        issue(1, 0, 0, 2'b00, 1, 1, 1);
        tick();
        issue(1, 1, 0, 2'b01, 2, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_cancel_stall", int'(stall), 0);
        check("rst_cancel_count", int'(stall_count), 0);
        tick();
        check("rst_cancel_sel", int'(sel_src), 0);

        // counter saturation with five load-use stalls
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1, 0, 0, 2'b00, 1, 1, 1);
            tick();
            issue(1, 1, 0, 2'b01, 2, 1, 0);
            tick();
            tick();
        end
        check("sat_count", int'(stall_count), 3);
        check("model_sat_count", m_cnt, 3);
        do_reset();
        check("sat_reset_count", int'(stall_count), 0);

        nop();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- REG_AW, 4, register address width
- NSRC, 2, source operands per instruction (1..4)
- CNT_W, 16, stall counter width
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- forward_en  in  1  1 = forwarding mode, 0 = stall-only mode
- freeze  in  1  global pipeline hold
- flush  in  1  discard ID instruction (taken branch)
- id_valid  in  1  ID stage holds a real instruction
- id_src  in  NSRC*REG_AW  ID source addresses, source k at [k*REG_AW +: REG_AW]
- id_src_used  in  NSRC  per-source read enable
- id_dest  in  REG_AW  ID destination address
- id_wb_en  in  1  ID instruction writes back
- id_mem_rd  in  1  ID instruction is a load
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- sel_src  out  NSRC*2  per-source EX operand mux select, registered
- stall_count  out  CNT_W  saturating count of stall cycles
REQ-003 There SHALL be one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL keep shadow records {valid, dest, wb_en, mem_rd} for EX, MEM and WB, mirroring the datapath pipeline registers.
REQ-005 sel_src encoding per source SHALL be: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 SHALL never be driven.
REQ-006 A source k SHALL match a record when id_src_used[k]=1, the record is valid, wb_en=1, and the addresses are equal.
REQ-007 With forward_en=1, stall SHALL be 1 when id_valid=1 and any source matches the EX record while EX mem_rd=1, which is a load-use hazard.
REQ-008 With forward_en=0, stall SHALL be 1 when id_valid=1 and any source matches the EX record or the MEM record.
REQ-009 stall SHALL be combinational from the current inputs and records, with zero latency.
REQ-010 On advance (no rst, no freeze, no flush, no stall), the ID fields SHALL load into EX (valid=id_valid), EX SHALL shift into MEM, and MEM SHALL shift into WB.
REQ-011 On advance, sel_src[k] SHALL register 01 if source k matches the current EX record, otherwise 10 if it matches the current MEM record, otherwise 00; EX SHALL take priority over MEM. All fields SHALL be 00 when forward_en=0.
REQ-012 On stall (no freeze, no flush), the EX record SHALL become a bubble (valid=0) with sel_src=0, and MEM and WB SHALL still shift.
REQ-013 On flush (no freeze), the EX record SHALL become a bubble with sel_src=0 and MEM/WB SHALL shift; flush SHALL override stall.
REQ-014 On freeze, all records, sel_src and stall_count SHALL hold; stall SHALL still be computed combinationally.
REQ-015 Update priority SHALL be rst > freeze > flush > stall > advance.
REQ-016 stall_count SHALL increment by 1 on each non-frozen, non-flushed cycle with stall=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-017 Simultaneous matches on several sources SHALL be resolved independently per source; duplicate addresses across sources SHALL yield identical selects.

Reset
REQ-018 On rst, all records SHALL be invalid with zeroed fields, sel_src SHALL be 0 and stall_count SHALL be 0; stall SHALL be 0 in the following cycle.
REQ-019 An rst asserted mid-stall SHALL cancel the stall, and the ID instruction SHALL be re-presented by the datapath.

Structure
REQ-020 Shared package fwd_pkg SHALL hold the sel encodings (SEL_RF, SEL_EXMEM, SEL_MEMWB) and the stage record typedef.
REQ-021 One sub-module, fwd_src_match, SHALL compare a single source against the EX and MEM records and return {match_ex, match_mem, load_use}; it SHALL be instantiated NSRC times.

Verification
REQ-022 Sequence "ADD r1; SUB r2=r1+r3", forward_en=1 -> SUB in EX has sel_src[0]=01, stall never asserted.
REQ-023 Sequence "LDR r1; NOP; ADD r2=r1" -> ADD in EX has sel_src[0]=10.
REQ-024 Sequence "LDR r1; ADD r2=r1", forward_en=1 -> exactly 1 stall cycle, bubble in EX, then sel_src[0]=10 and stall_count=1.
REQ-025 The REQ-022 sequence with forward_en=0 -> 2 stall cycles, sel_src=00 throughout and stall_count=2.
REQ-026 Load-use stall with flush=1 in the same cycle -> EX bubble, MEM shifts, stall_count unchanged; the same stall with freeze=1 -> all state held.
REQ-027 With CNT_W=2 and 5 consecutive load-use stalls -> stall_count saturates at 3; rst then clears it to 0.
